// File: rtl/key_recorder_if.sv
// key_recorder_if: control, strobe and read-port bundle for key_recorder.
// master = keyboard/host side, slave = recorder.
interface key_recorder_if #(
  parameter int MEM_DEPTH = 1024
);
  localparam int AW = $clog2(MEM_DEPTH);

  logic          start;
  logic          stop;
  logic          clk_msg;
  logic [7:0]    msg;
  logic [AW-1:0] rd_addr;
  logic [15:0]   rd_data;
  logic [AW:0]   len;
  logic          busy;
  logic          full;
  logic          overflow;

  modport master (
    output start, stop, clk_msg, msg, rd_addr,
    input  rd_data, len, busy, full, overflow
  );

  modport slave (
    input  start, stop, clk_msg, msg, rd_addr,
    output rd_data, len, busy, full, overflow
  );
endinterface

// File: rtl/key_recorder.sv
// key_recorder: records {beats, msg} entries of the key stream into memory.
// Define REC_LOOP_EN to turn the memory into a ring buffer when full.
module key_recorder #(
  parameter int CLK_FREQ       = 120_000_000,
  parameter int MEM_DEPTH      = 1024,
  parameter int MS_PER_BEATX64 = 9
) (
  input  logic clk,
  input  logic rst,
  key_recorder_if.slave bus
);
  localparam int TICKS = CLK_FREQ / 1000;
  localparam int PW = (TICKS > 1) ? $clog2(TICKS) : 1;
  localparam int SW = (MS_PER_BEATX64 > 1) ?
                      $clog2(MS_PER_BEATX64) : 1;
  localparam int AW = $clog2(MEM_DEPTH);
  localparam logic [AW:0]   DEPTH   = (AW+1)'(MEM_DEPTH);
  localparam logic [PW-1:0] PRE_MAX = PW'(TICKS - 1);
  localparam logic [SW-1:0] SUB_MAX = SW'(MS_PER_BEATX64 - 1);

  typedef enum logic [1:0] {
    IDLE,
    ARMED,
    REC
  } state_t;

  state_t        state_q;
  logic [PW-1:0] pre_q;
  logic [SW-1:0] sub_q;
  logic [7:0]    beats_q;
  logic [2:0]    sync_q;
  logic          stb_q;
  logic [7:0]    msg_q;
  logic [AW:0]   len_q;
  logic [AW-1:0] wptr_q;
  logic [AW-1:0] base_q;
  logic          ovf_q;
  logic          busy_q;
  logic [15:0]   rd_data_q;
  logic [15:0]   mem_q [MEM_DEPTH];

  logic          tick;
  logic          edge_det;
  logic          active;
  logic          room;
  logic          accept;
  logic          do_wr;
  logic          drop;
  logic [15:0]   wr_data;
  logic [AW-1:0] rd_idx;

  assign tick     = (pre_q == PRE_MAX);
  assign edge_det = sync_q[1] & ~sync_q[2];
  assign rd_idx   = base_q + bus.rd_addr;

  // Free-running 1 ms prescaler.
  always_ff @(posedge clk) begin
    if (rst || tick) pre_q <= '0;
    else             pre_q <= pre_q + 1'b1;
  end

  // Beat counter: ms -> beat units, saturating, cleared on each write.
  always_ff @(posedge clk) begin
    if (rst || do_wr) begin
      sub_q   <= '0;
      beats_q <= '0;
    end else if (tick) begin
      if (sub_q == SUB_MAX) begin
        sub_q <= '0;
        if (beats_q != 8'hFF) beats_q <= beats_q + 8'd1;
      end else begin
        sub_q <= sub_q + 1'b1;
      end
    end
  end

  // Two-flop synchronizer plus edge delay, msg captured on the edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q <= '0;
      stb_q  <= 1'b0;
      msg_q  <= '0;
    end else begin
      sync_q <= {sync_q[1:0], bus.clk_msg};
      stb_q  <= edge_det;
      if (edge_det) msg_q <= bus.msg;
    end
  end

  // Write decision: start wins over a coincident strobe.
  always_comb begin
    active  = (state_q == ARMED) || (state_q == REC);
    room    = (len_q != DEPTH);
    accept  = stb_q && active && !bus.start;
`ifdef REC_LOOP_EN
    do_wr   = accept;
`else
    do_wr   = accept && room;
`endif
    drop    = accept && !room;
    wr_data = {(state_q == REC) ? beats_q : 8'd0, msg_q};
  end

  // Take control FSM with registered status outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      len_q   <= '0;
      wptr_q  <= '0;
      base_q  <= '0;
      ovf_q   <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (bus.start) begin
            state_q <= ARMED;
            len_q   <= '0;
            wptr_q  <= '0;
            base_q  <= '0;
            ovf_q   <= 1'b0;
            busy_q  <= 1'b1;
          end
        end
        ARMED, REC: begin
          if (bus.start) begin
            state_q <= ARMED;
            len_q   <= '0;
            wptr_q  <= '0;
            base_q  <= '0;
            ovf_q   <= 1'b0;
            busy_q  <= 1'b1;
          end else begin
            if (do_wr) begin
              wptr_q <= wptr_q + 1'b1;
              if (room) len_q  <= len_q + 1'b1;
              else      base_q <= base_q + 1'b1;
            end
            if (drop) ovf_q <= 1'b1;
            if (bus.stop) begin
              state_q <= IDLE;
              busy_q  <= 1'b0;
            end else if (do_wr) begin
              state_q <= REC;
            end
          end
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  // Music memory write port; contents survive reset.
  always_ff @(posedge clk) begin
    if (do_wr && !rst) mem_q[wptr_q] <= wr_data;
  end

  // Registered read, relative to the oldest entry of the take.
  always_ff @(posedge clk) begin
    if (rst) rd_data_q <= '0;
    else     rd_data_q <= mem_q[rd_idx];
  end

  assign bus.rd_data  = rd_data_q;
  assign bus.len      = len_q;
  assign bus.busy     = busy_q;
  assign bus.full     = (len_q == DEPTH);
  assign bus.overflow = ovf_q;
endmodule

// File: doc/key_recorder.md
Name: key_recorder

Overview:
- Captures the live key-message stream (8-bit msg plus clk_msg strobe) and writes it into an internal music memory.
- Each 16-bit entry is {beats_since_previous_msg[15:8], msg[7:0]}, the same format the playback path reads, so a recorded take can be replayed or dumped.
- Sits beside the keyboard scanner, in the same clk domain as the playback block; has its own 1 kHz time base.

Parameters:
- CLK_FREQ, 120_000_000, system clock frequency in Hz; the ms tick period is CLK_FREQ/1000 cycles.
- MEM_DEPTH, 1024, number of 16-bit entries in the memory (power of two).
- MS_PER_BEATX64, 9, ms per beat unit; sets the time quantum of the duration byte.

Ports:
- clk  input  1  system clock
- rst  input  1  synchronous active-high reset
- start  input  1  one-cycle pulse; begins a new take
- stop  input  1  one-cycle pulse; ends the take
- clk_msg  input  1  message strobe from keyboard; may be asynchronous; active on rising edge
- msg  input  8  message byte; held stable by the source around the clk_msg rising edge
- rd_addr  input  log2(MEM_DEPTH)  read index, 0 = oldest entry of the take
- rd_data  output  16  entry at rd_addr, registered
- len  output  log2(MEM_DEPTH)+1  number of valid entries
- busy  output  1  high in ARMED or REC
- full  output  1  len == MEM_DEPTH
- overflow  output  1  sticky; a message was dropped, or overwrote data when REC_LOOP_EN is defined

Behaviour:
- Reset (synchronous, active-high) sets rd_data=0, len=0, busy=0, full=0, overflow=0, state IDLE, all counters 0. Memory contents are not cleared.
- Time base: prescaler counts 0..CLK_FREQ/1000-1 and emits a 1-cycle ms_tick on wrap. The prescaler runs continuously, including in IDLE.
- Beat counter:
  - sub counter 0..MS_PER_BEATX64-1 advances on ms_tick; on its wrap, beats increments.
  - beats saturates at 255 and never wraps.
- Strobe path:
  - clk_msg passes through a 2-flop synchronizer, then a rising-edge detector.
  - msg is sampled on the cycle the edge is detected (3 cycles after the input edge).
  - The write occurs on the following cycle.
- States:
  - IDLE: start → ARMED; clears len, overflow, write pointer and base pointer. Strobes are ignored.
  - ARMED: first detected strobe writes {8'd0, msg}, clears beats/sub, → REC. stop → IDLE.
  - REC:
    - Each detected strobe writes {beats, msg} at the write pointer, increments the pointer and len, and clears beats and sub in the same cycle.
    - If beats was already 255, it is written as 255.
    - stop → IDLE.
  - A detected strobe and stop in the same cycle: the write happens first, then IDLE.
  - start while ARMED or REC restarts the take; len is cleared.
- Full (REC_LOOP_EN not defined):
  - When len == MEM_DEPTH, further strobes are not written; overflow is set to 1 and stays set.
  - State remains REC until stop.
- Read port:
  - rd_data = mem[(base + rd_addr) mod MEM_DEPTH], registered, 1-cycle latency. Reads are legal in every state.
  - rd_addr >= len returns stale memory, not an error.
  - A read and a write to the same address in one cycle return the old data.
- Reset mid-take returns to IDLE and sets len=0. Already-written entries stay in memory but are no longer counted.

Optional Feature:
- Macro: REC_LOOP_EN.
- Defined: the memory is a ring buffer.
  - When full, a new strobe overwrites the oldest entry.
  - base pointer advances by 1 (mod MEM_DEPTH); len stays MEM_DEPTH.
  - overflow is set on the first overwrite.
  - rd_addr 0 always addresses the oldest surviving entry.
- Not defined: stop-when-full behaviour above; base pointer stays 0.

Test Plan:
- CLK_FREQ=10_000 (10 cycles/ms), MS_PER_BEATX64=2: start, strobe msg=8'h3C, wait 40 ms, strobe msg=8'h40 → len=2; rd_addr 0 → 16'h003C, rd_addr 1 → 16'h1440 (20 beats ±1).
- Strobe clk_msg in IDLE → len stays 0, no memory write; start then stop without any strobe → len=0, busy returns to 0.
- Wait >600 ms between two strobes in REC → second entry duration byte = 8'hFF (saturated).
- MEM_DEPTH=4, REC_LOOP_EN not defined, 6 strobes msg=1..6 → len=4, full=1, overflow=1, entries hold msgs 1..4.
- MEM_DEPTH=4, REC_LOOP_EN defined, 6 strobes msg=1..6 → len=4, overflow=1, rd_addr 0..3 → msgs 3,4,5,6.
- Strobe and stop asserted in the same cycle → entry written, len increments, state IDLE; rst mid-take → len=0, busy=0 on the next cycle.
